// File: rtl/muldiv_sequencer.sv
// Iterative MULTU/DIVU engine owning HI/LO; 32 iterations, issue-to-done WIDTH+1 cycles (divide-by-zero: 1).
// No input backpressure of its own: raises stall while busy and the EX stage needs HI/LO or the unit.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_wd,
  input  logic             mf_req,
  input  logic             abort,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 op_r;
  logic [WIDTH-1:0]     opnd;      // multiplicand for MULTU, divisor for DIVU
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH:0]       rem;
  logic [WIDTH-1:0]     quo;

  logic                 issue;
  logic                 div_zero;
  logic                 last;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   prod_nxt;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH+1:0]     trial;
  logic [WIDTH:0]       rem_nxt;
  logic [WIDTH-1:0]     quo_nxt;

  assign issue    = (state == IDLE) && start && !abort;
  assign div_zero = issue && op && (b == '0);
  assign last     = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue && !div_zero) state_nxt = RUN;
      RUN:     if (abort || last)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy  = (state == RUN);
    stall = busy && (start || mf_req || mthi || mtlo);
  end

  // One shift-add step on the 65-bit {carry, P_hi, P_lo}, keeping the low 64 after the shift
  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
    prod_nxt = {mul_sum, prod[WIDTH-1:1]};
  end

  // Restoring step; R's MSB is always 0 here because R < divisor, so dropping it is lossless
  always_comb begin
    rem_sh  = (WIDTH+1)'({rem, quo[WIDTH-1]});
    trial   = {1'b0, rem_sh} - {2'b00, opnd};
    rem_nxt = trial[WIDTH+1] ? rem_sh : trial[WIDTH:0];
    quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH+1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      op_r <= 1'b0;
      opnd <= '0;
      prod <= '0;
      rem  <= '0;
      quo  <= '0;
      done <= 1'b0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (issue) begin
          if (div_zero) begin
            hi   <= a;
            lo   <= '1;
            done <= 1'b1;
          end else begin
            op_r <= op;
            cnt  <= '0;
            opnd <= op ? b : a;
            prod <= {{WIDTH{1'b0}}, b};
            rem  <= '0;
            quo  <= a;
          end
        end else if (!abort && !start) begin
          if (mthi) hi <= mt_wd;
          if (mtlo) lo <= mt_wd;
        end
      end else if (!abort) begin
        cnt <= cnt + 1'b1;
        if (op_r) begin
          rem <= rem_nxt;
          quo <= quo_nxt;
        end else begin
          prod <= prod_nxt;
        end
        if (last) begin
          done <= 1'b1;
          hi   <= op_r ? WIDTH'(rem_nxt) : prod_nxt[2*WIDTH-1:WIDTH];
          lo   <= op_r ? quo_nxt         : prod_nxt[WIDTH-1:0];
        end
      end
    end
  end

endmodule
